// File: rtl/spu_ls_responder.sv
// spu_ls_responder
// ----------------
// Local-store responder for the cellspu core. It holds a single-port quadword
// SRAM array behind a request/ready handshake with a programmable access
// latency. It serves data loads, data stores and dual-instruction fetches.
//
// Optional feature (macro LS_PARITY_EN):
//   Each quadword carries an even-parity bit and a valid bit.
//   The valid bit is cleared by reset.
//   Loads and fetches flag err on a parity mismatch or on a never-written
//   location, and they still return the data.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   memread    in   data load request
//   memwrite   in   data store request
//   ifetch     in   instruction fetch request
//   adr        in   byte address (quadword index = adr[LSBITS+3:4])
//   writedata  in   store data
//   ready      out  responder idle; a request is accepted on an edge where ready=1
//   memdata    out  load data, held until the next load response
//   dvalid     out  one-cycle pulse, load/store complete
//   instr0     out  instruction at the even word of the fetched pair
//   instr1     out  instruction at the following word
//   ivalid     out  one-cycle pulse, instr0/instr1 valid
//   err        out  one-cycle pulse alongside dvalid/ivalid for a bad request
module spu_ls_responder #(
  parameter int RFWIDTH = 128,
  parameter int WIDTH   = 32,
  parameter int LSBITS  = 10,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memread,
  input  logic               memwrite,
  input  logic               ifetch,
  input  logic [WIDTH-1:0]   adr,
  input  logic [RFWIDTH-1:0] writedata,
  output logic               ready,
  output logic [RFWIDTH-1:0] memdata,
  output logic               dvalid,
  output logic [WIDTH-1:0]   instr0,
  output logic [WIDTH-1:0]   instr1,
  output logic               ivalid,
  output logic               err
);

  localparam int DEPTH = 1 << LSBITS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {K_READ, K_WRITE, K_FETCH, K_ILLEGAL} kind_t;

  state_t              state, state_next;
  logic [3:0]          cnt, cnt_next;
  kind_t               kind_in, kind_q;
  logic [LSBITS-1:0]   idx_q;
  logic                wsel_q;
  logic                oor_q;
  logic [RFWIDTH-1:0]  wdata_q;
  logic [RFWIDTH-1:0]  mem [DEPTH];
  logic [RFWIDTH-1:0]  rdata;
  logic                accept;
  logic                access;
  logic                write_en;
  logic                par_bad;
  logic [WIDTH-1:0]    fetch0, fetch1;
  logic                unused_adr_bits;

  // Byte and word-within-pair bits play no part in selecting the data.
  assign unused_adr_bits = &{1'b0, adr[2:0]};

  // A simultaneous read and write is illegal. Otherwise data requests beat
  // an instruction fetch. The losing fetch is simply not latched.
  always_comb begin
    kind_in = K_FETCH;
    if (memread && memwrite) kind_in = K_ILLEGAL;
    else if (memread)        kind_in = K_READ;
    else if (memwrite)       kind_in = K_WRITE;
  end

  assign ready    = (state == IDLE);
  assign accept   = ready && (memread || memwrite || ifetch);
  assign access   = (state == WAIT) && (cnt == 4'd0);
  assign write_en = access && (kind_q == K_WRITE) && !oor_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: if (accept) begin
        state_next = WAIT;
        cnt_next   = 4'(LATENCY - 1);
      end
      WAIT: if (cnt == 4'd0) state_next = RESP;
            else             cnt_next   = cnt - 4'd1;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture. Only the fields needed later are kept.
  // The out-of-range decision is made once, at acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kind_q  <= K_READ;
      idx_q   <= '0;
      wsel_q  <= 1'b0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      kind_q  <= kind_in;
      idx_q   <= adr[LSBITS+3:4];
      wsel_q  <= adr[3];
      oor_q   <= |adr[WIDTH-1:LSBITS+4];
      wdata_q <= writedata;
    end
  end

  // The array itself is never reset.
  // A store is dropped by reset because reset forces the FSM out of WAIT
  // before the write edge.
  always_ff @(posedge clk) begin
    if (write_en) mem[idx_q] <= wdata_q;
  end

  assign rdata = mem[idx_q];

  // The fetch pair starts at word 0 or word 2. Words are little-endian.
  assign fetch0 = wsel_q ? rdata[2*WIDTH +: WIDTH] : rdata[0 +: WIDTH];
  assign fetch1 = wsel_q ? rdata[3*WIDTH +: WIDTH] : rdata[WIDTH +: WIDTH];

`ifdef LS_PARITY_EN
  logic             par_mem [DEPTH];
  logic [DEPTH-1:0] par_valid;

  always_ff @(posedge clk) begin
    if (write_en) par_mem[idx_q] <= ^wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        par_valid <= '0;
    else if (write_en) par_valid[idx_q] <= 1'b1;
  end

  // A never-written location counts as a mismatch.
  assign par_bad = !par_valid[idx_q] || ((^rdata) != par_mem[idx_q]);
`else
  assign par_bad = 1'b0;
`endif

  // The response registers load on the access edge, so the pulses are high
  // exactly during RESP.
  // memdata and instr0/instr1 then hold until the next response of their kind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvalid  <= 1'b0;
      ivalid  <= 1'b0;
      err     <= 1'b0;
      memdata <= '0;
      instr0  <= '0;
      instr1  <= '0;
    end else begin
      dvalid <= 1'b0;
      ivalid <= 1'b0;
      err    <= 1'b0;
      if (access) begin
        unique case (kind_q)
          K_ILLEGAL: begin
            dvalid  <= 1'b1;
            err     <= 1'b1;
            memdata <= '0;
          end
          K_READ: begin
            dvalid <= 1'b1;
            if (oor_q) begin
              err     <= 1'b1;
              memdata <= '0;
            end else begin
              err     <= par_bad;
              memdata <= rdata;
            end
          end
          K_WRITE: begin
            dvalid <= 1'b1;
            err    <= oor_q;
          end
          K_FETCH: begin
            ivalid <= 1'b1;
            if (oor_q) begin
              err    <= 1'b1;
              instr0 <= '0;
              instr1 <= '0;
            end else begin
              err    <= par_bad;
              instr0 <= fetch0;
              instr1 <= fetch1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spu_ls_responder.md
Name: spu_ls_responder

Overview:
- Local-store responder for the cellspu core; it is the memory end of the core's memread/memwrite/adr/writedata/memdata interface.
- Single-port quadword SRAM array with a request/ready handshake and programmable access latency.
- Serves data loads, stores and dual-instruction fetches (instr0/instr1 for the even/odd pipes).
- Replaces the zero-latency behavioural memory so the core's stall logic is exercised.

Parameters:
- RFWIDTH, 128, quadword data width in bits.
- WIDTH, 32, address and instruction width.
- LSBITS, 10, log2 of the number of quadwords stored (1024 quadwords = 16 KB).
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memread  in  1  data load request.
- memwrite  in  1  data store request.
- ifetch  in  1  instruction fetch request.
- adr  in  WIDTH  byte address; quadword index = adr[LSBITS+3:4].
- writedata  in  RFWIDTH  store data.
- ready  out  1  responder idle; a request is accepted on a clk edge where ready=1.
- memdata  out  RFWIDTH  load data; valid while dvalid=1.
- dvalid  out  1  one-cycle pulse, load or store complete.
- instr0  out  WIDTH  fetched instruction at the even word address.
- instr1  out  WIDTH  instruction at the following word.
- ivalid  out  1  one-cycle pulse, instr0/instr1 valid.
- err  out  1  one-cycle pulse with dvalid/ivalid for an erroneous request.

Behaviour:
- Reset (reset=0, async) values:
  - ready=1; dvalid=0, ivalid=0, err=0.
  - memdata=0, instr0=0, instr1=0.
  - FSM to IDLE, latency counter to 0.
  - Array contents are not cleared.
- FSM states:
  - IDLE: ready=1. Sample the request on the clk edge. Accepting a request latches kind, adr and writedata and goes to WAIT with cnt=LATENCY-1.
  - WAIT: ready=0. Decrement cnt each cycle. At cnt=0 perform the array access and go to RESP.
  - RESP: drive the pulse (dvalid or ivalid, plus err if applicable) for exactly one cycle, then return to IDLE. ready=1 again in the cycle after RESP.
  - Back-to-back throughput is one request per LATENCY+2 cycles.
- Arbitration among simultaneous requests in IDLE:
  - memread and memwrite both high: illegal. Accept it, perform no access, respond dvalid=1, err=1, memdata=0.
  - Otherwise data (read/write) beats ifetch.
  - A losing ifetch is not latched; the requester must hold it until ready=1 and it is accepted.
- Requests arriving while ready=0 are ignored; no queueing.
- Load: memdata = array[idx] on the RESP cycle and held until the next load response. Store: array[idx] is written in the last WAIT cycle; memdata is unchanged.
- Fetch:
  - Word select w = adr[3:2] & 2'b10.
  - instr0 = word w of array[idx]; instr1 = word w+1; words are little-endian within the quadword.
  - Outputs hold until the next fetch response.
- Out of range: if adr[WIDTH-1:LSBITS+4] != 0 the request is accepted, there is no array access, err=1 with the normal response pulse, and the returned data is 0.
- Reset asserted mid-operation: the pending request is dropped with no response pulse. A store is written only if reset was not asserted before its write edge.
- Unaligned adr[1:0] bits are ignored.

Optional Feature:
- Macro: LS_PARITY_EN.
- Defined:
  - Each quadword carries one even-parity bit, written on every store.
  - Loads and fetches recompute parity; a mismatch raises err=1 with the response pulse, while data is still returned.
  - Never-written locations are treated as mismatched: a valid bit per quadword is cleared by reset.
- Not defined: no parity storage; err is asserted only for illegal or out-of-range requests.

Test Plan:
- Reset, then store writedata=7 at adr=0x50, LATENCY=2 -> ready low for 3 cycles, dvalid pulse on cycle 3 after acceptance, err=0.
- Load from adr=0x50 -> dvalid pulse exactly LATENCY+1 cycles after acceptance, memdata=7.
- Preload words 0x11,0x22,0x33,0x44 at quadword 2; ifetch adr=0x2C -> ivalid, instr0=0x33, instr1=0x44.
- memread and ifetch both high at the same edge -> load serviced first; ifetch held high is accepted on the first ready=1 cycle and returns correct instructions.
- memread=1 with memwrite=1, and a separate load at adr=0x00010000 -> each gives err=1 with dvalid and memdata=0; the array is unchanged.
- Pull reset low during WAIT of a store -> no dvalid, ready=1 immediately, and a later load from the same address returns the old value. With LS_PARITY_EN, a load of a never-written address gives err=1.
